// File: rtl/uart_tx_sched_if.sv
// Bundle between the UART transmit scheduler, its requesters and the frame transmitter.
// master = scheduler side, slave = requesters/transmitter side.
interface uart_tx_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   grant;
   logic              tx_send;
   logic [7:0]        tx_data;
   logic              tx_active;
   logic              tx_done;
   logic [2:0]        owner;
   logic              busy;
   logic              err;

   modport master (
      input  req, req_data, tx_active, tx_done,
      output grant, tx_send, tx_data, owner, busy, err
   );

   modport slave (
      output req, req_data, tx_active, tx_done,
      input  grant, tx_send, tx_data, owner, busy, err
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Optional frame watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | arbitrate over req, starting after last_owner
// S_LOAD      | grant pulse, latch winner's byte, raise tx_send
// S_WAIT_ACT  | wait for transmitter to report busy (tx_done ignored)
// S_WAIT_DONE | wait for tx_done with tx_active low, then drop tx_send
// S_GAP       | one cycle with tx_send low before the next frame
module uart_tx_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic            i_clk,
   input  logic            i_rst,
   uart_tx_sched_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_ACT, S_WAIT_DONE, S_GAP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_last_owner;
   logic [2:0]      r_winner;
   logic [2:0]      r_owner;
   logic [7:0]      r_tx_data;
   logic            r_tx_send;
   logic            r_busy;

   logic [3:0]      w_start;
   logic [NREQ-1:0] w_rot;
   logic [3:0]      w_off;
   logic [3:0]      w_sum;
   logic            w_any;
   logic [2:0]      w_winner;
   logic [7:0]      w_sel_data;
   logic [NREQ-1:0] w_grant;
   logic            w_frame_done;
   logic            w_tmo;

   // Rotate the request vector so bit 0 is the requester after last_owner.
   assign w_start = {1'b0, r_last_owner} + 4'd1;
   assign w_rot   = NREQ'({bus.req, bus.req} >> w_start);

   always_comb begin
      w_any = 1'b0;
      w_off = 4'd0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_any = 1'b1;
            w_off = 4'(j);
         end
      end
      w_sum = w_start + w_off;
      if (w_sum >= 4'(NREQ)) w_sum = w_sum - 4'(NREQ);
      w_winner = w_sum[2:0];
   end

   assign w_sel_data   = 8'(bus.req_data >> {r_winner, 3'b000});
   assign w_frame_done = bus.tx_done && !bus.tx_active;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_any) w_next = S_LOAD;
         S_LOAD:      w_next = S_WAIT_ACT;
         S_WAIT_ACT: begin
            if (bus.tx_active) w_next = S_WAIT_DONE;
            else if (w_tmo)    w_next = S_GAP;
         end
         S_WAIT_DONE: if (w_frame_done || w_tmo) w_next = S_GAP;
         S_GAP:       w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_grant = '0;
      if (r_state == S_LOAD) w_grant = {{(NREQ-1){1'b0}}, 1'b1} << r_winner;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_last_owner <= 3'(NREQ - 1);
         r_winner     <= 3'd0;
         r_owner      <= 3'd0;
         r_tx_data    <= 8'h00;
         r_tx_send    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any) r_winner <= w_winner;
            S_LOAD: begin
               r_tx_data <= w_sel_data;
               r_owner   <= r_winner;
               r_tx_send <= 1'b1;
               r_busy    <= 1'b1;
            end
            S_WAIT_ACT, S_WAIT_DONE: begin
               if (w_next == S_GAP) begin
                  r_tx_send    <= 1'b0;
                  r_last_owner <= r_owner;
               end
            end
            S_GAP:   r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_tmr;
   logic          r_err;
   logic          w_waiting;

   assign w_waiting = (r_state == S_WAIT_ACT) || (r_state == S_WAIT_DONE);
   assign w_tmo     = w_waiting && (r_tmr == '0);

   // Terminal count reached after TIMEOUT cycles spent in the wait states.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_tmr <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_LOAD)             r_tmr <= TW'(TIMEOUT - 1);
         else if (w_waiting && r_tmr != '0) r_tmr <= r_tmr - 1'b1;
         if ((r_state == S_WAIT_ACT && !bus.tx_active && w_tmo) ||
             (r_state == S_WAIT_DONE && !w_frame_done && w_tmo))
            r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   assign w_tmo   = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.grant   = w_grant;
   assign bus.tx_send = r_tx_send;
   assign bus.tx_data = r_tx_data;
   assign bus.owner   = r_owner;
   assign bus.busy    = r_busy;
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, 4096, clk cycles allowed per frame before abort (used only with REQ-030).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NREQ  per-requester transmit request, level; held until granted.
REQ-006 req_data  in  8*NREQ  byte per requester, slice i = bits [8i+7:8i].
REQ-007 grant  out  NREQ  one-hot, one-cycle pulse; requester i's byte latched this cycle.
REQ-008 tx_send  out  1  level "send" to transmitter; held for the whole frame.
REQ-009 tx_data  out  8  latched byte presented to the frame builder.
REQ-010 tx_active  in  1  transmitter busy, from transmitter.
REQ-011 tx_done  in  1  transmitter frame done/idle, from transmitter.
REQ-012 owner  out  3  index of requester currently served; valid while busy=1.
REQ-013 busy  out  1  high from grant through frame completion.
REQ-014 err  out  1  sticky timeout flag (REQ-030); constant 0 when feature absent.

Function
REQ-015 States IDLE, LOAD, WAIT_ACT, WAIT_DONE, GAP; encoding free.
REQ-016 IDLE: if any req bit set, select winner by round-robin starting at (last_owner+1) mod NREQ, wrapping; go LOAD; else stay.
REQ-017 LOAD (1 cycle): grant[winner]=1, tx_data<=req_data slice, owner<=winner, tx_send<=1, busy<=1; go WAIT_ACT.
REQ-018 WAIT_ACT: stay until tx_active=1 (tx_done is high when transmitter idle, so done is ignored here); then go WAIT_DONE.
REQ-019 WAIT_DONE: on first cycle with tx_done=1 and tx_active=0, tx_send<=0, last_owner<=owner; go GAP.
REQ-020 GAP (1 cycle): busy<=0; return IDLE; guarantees transmitter sees send low before next frame.
REQ-021 Grant-to-next-grant minimum = frame time + 3 clk cycles; grant never issued while busy=1.
REQ-022 tx_data and owner stable from LOAD until next LOAD.
REQ-023 Requester dropping req after grant has no effect on current frame; req dropped before grant is never served.
REQ-024 Only one requester active: served every frame, no starvation cycles inserted beyond REQ-020.
REQ-025 All requesters active: service order strictly i, i+1, ... wrapping; each waits at most NREQ-1 frames.
REQ-026 req change in same cycle as tx_done: arbitration uses req sampled in IDLE only.

Reset
REQ-027 rst low at any time (including mid-frame): state IDLE, tx_send=0, grant=0, busy=0, tx_data=0x00, owner=0, err=0, last_owner=NREQ-1 (so requester 0 wins first).
REQ-028 Reset asserted mid-frame leaves transmitter to abort via its own reset; no resumption of interrupted frame.
REQ-029 After rst deasserts, first grant no earlier than second rising clk edge.

Configuration
REQ-030 Macro UART_TX_SCHED_TIMEOUT_EN defined: counter runs in WAIT_ACT/WAIT_DONE; reaching TIMEOUT forces tx_send<=0, err<=1 (sticky until reset), go GAP, last_owner<=owner.
REQ-031 Macro undefined: no counter logic; WAIT_ACT/WAIT_DONE wait indefinitely; err tied 0.

Verification
REQ-032 Reset then req=4'b0001, data0=0x55 -> grant=0001 one cycle, tx_data=0x55, tx_send high until tx_done, busy low 1 cycle after.
REQ-033 req=4'b1111 held, bytes 0xA0..0xA3 -> grants 0001,0010,0100,1000,0001 in order, tx_data sequence A0,A1,A2,A3,A0.
REQ-034 req=4'b1010 after owner=1 served -> next grant 1000, then 0010.
REQ-035 rst pulsed low during WAIT_DONE -> all outputs reset values same cycle (async), next grant goes to requester 0.
REQ-036 TIMEOUT_EN, TIMEOUT=16, tx_active held 0 -> tx_send drops after 16 cycles, err=1, next requester granted.
REQ-037 tx_done kept 1 (idle transmitter) during WAIT_ACT -> no premature completion; send held until tx_active seen.
